// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - IF/ID decoupling queue of {PC+4, instruction} pairs with branch flush
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_PC,
    input  logic [31:0]      if_Instruction,
    output logic             if_ready,
    input  logic             id_stall,
    input  logic             flush,
    output logic             id_valid,
    output logic [31:0]      id_PC,
    output logic [31:0]      id_Instruction,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]      entry [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    assign if_ready = (count != CNT_W'(DEPTH));
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & ~id_stall & ~flush;

    // Show-ahead head; zeroed when empty since stale entries are never cleared
    assign id_PC          = id_valid ? entry[rd_ptr][63:32] : 32'd0;
    assign id_Instruction = id_valid ? entry[rd_ptr][31:0]  : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            entry[wr_ptr] <= {if_PC, if_Instruction};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb/tb_if_id_fetch_queue.sv - scoreboard bench for if_id_fetch_queue
module tb_if_id_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid;
    logic [31:0]      if_PC;
    logic [31:0]      if_Instruction;
    logic             if_ready;
    logic             id_stall;
    logic             flush;
    logic             id_valid;
    logic [31:0]      id_PC;
    logic [31:0]      id_Instruction;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic [63:0] sb_q[$];

    if_id_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_PC(if_PC), .if_Instruction(if_Instruction),
        .if_ready(if_ready), .id_stall(id_stall), .flush(flush),
        .id_valid(id_valid), .id_PC(id_PC), .id_Instruction(id_Instruction),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hE1A0_0000 + pc;
    endfunction

    // Scoreboard: compare at negedge against the model, then advance the model for the coming edge
    always @(negedge clk) begin
        if (mon_en) begin
            logic [63:0] head;
            int n;
            n = sb_q.size();
            head = (n != 0) ? sb_q[0] : 64'd0;
            total += 4;
            if (count !== CNT_W'(n)) begin
                bad++; $display("FAIL sb_count got=%0d exp=%0d", count, n);
            end
            if (id_valid !== (n != 0)) begin
                bad++; $display("FAIL sb_id_valid got=%0b exp=%0b", id_valid, n != 0);
            end
            if (if_ready !== (n != DEPTH)) begin
                bad++; $display("FAIL sb_if_ready got=%0b exp=%0b", if_ready, n != DEPTH);
            end
            if ({id_PC, id_Instruction} !== head) begin
                bad++; $display("FAIL sb_head got=%h exp=%h", {id_PC, id_Instruction}, head);
            end
            if (rst || flush) begin
                sb_q.delete();
            end else begin
                if (n != 0 && !id_stall) void'(sb_q.pop_front());
                if (if_valid && n != DEPTH) sb_q.push_back({if_PC, if_Instruction});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc);
        if_valid = 1'b1;
        if_PC = pc;
        if_Instruction = instr_of(pc);
    endtask

    task automatic drain();
        int guard = 0;
        if_valid = 1'b0;
        id_stall = 1'b0;
        while (id_valid === 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 20) begin
            bad++; $display("FAIL drain_timeout got=%0d exp<20", guard);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; id_stall = 1'b0;
        drive_push(32'd500);
        step();
        step();
        rst = 1'b0;
        if_valid = 1'b0;
        mon_en = 1'b1;
        total += 5;
        if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
        if (id_PC !== 32'd0) begin bad++; $display("FAIL reset_id_PC got=%h exp=0", id_PC); end
        if (id_Instruction !== 32'd0) begin bad++; $display("FAIL reset_id_Instr got=%h exp=0", id_Instruction); end
        if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
    endtask

    task automatic test_fill();
        id_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_push(32'(4 * i));
            step();
        end
        total += 2;
        if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
        if (if_ready !== 1'b0) begin bad++; $display("FAIL fill_if_ready got=%0b exp=0", if_ready); end
        drive_push(32'd20);
        step();
        if_valid = 1'b0;
        total++;
        if (count !== 3'd4) begin bad++; $display("FAIL fill_overpush got=%0d exp=4", count); end
        id_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (id_PC !== 32'(4 * i) || id_Instruction !== instr_of(32'(4 * i))) begin
                bad++; $display("FAIL fill_pop%0d got=%h/%h exp=%h", i, id_PC, id_Instruction, 4 * i);
            end
            step();
        end
        total++;
        if (id_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0b exp=0", id_valid); end
    endtask

    task automatic test_concurrent();
        id_stall = 1'b1;
        drive_push(32'd4); step();
        drive_push(32'd8); step();
        drive_push(32'd12);
        id_stall = 1'b0;
        total++;
        if (id_PC !== 32'd4) begin bad++; $display("FAIL conc_head0 got=%0d exp=4", id_PC); end
        step();
        if_valid = 1'b0;
        total += 2;
        if (count !== 3'd2) begin bad++; $display("FAIL conc_count got=%0d exp=2", count); end
        if (id_PC !== 32'd8) begin bad++; $display("FAIL conc_head1 got=%0d exp=8", id_PC); end
        step();
        total++;
        if (id_PC !== 32'd12) begin bad++; $display("FAIL conc_head2 got=%0d exp=12", id_PC); end
        drain();
    endtask

    task automatic test_flush();
        id_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_push(32'(4 * i));
            step();
        end
        flush = 1'b1;
        id_stall = 1'b0;
        drive_push(32'd44);
        step();
        flush = 1'b0;
        total += 3;
        if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_id_valid got=%0b exp=0", id_valid); end
        if ({id_PC, id_Instruction} !== 64'd0) begin
            bad++; $display("FAIL flush_id_zero got=%h exp=0", {id_PC, id_Instruction});
        end
        drive_push(32'd104);
        step();
        if_valid = 1'b0;
        total++;
        if (id_PC !== 32'd104) begin bad++; $display("FAIL flush_next got=%0d exp=104", id_PC); end
        drain();
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int cyc = 0;
        while (pushed < 10 && cyc < 60) begin
            logic accept;
            id_stall = cyc[0];
            drive_push(32'(4 * (pushed + 1)));
            accept = (sb_q.size() != DEPTH);
            step();
            if (accept) pushed++;
            cyc++;
            total++;
            if (count > 3'd4) begin bad++; $display("FAIL wrap_count got=%0d exp<=4", count); end
        end
        total++;
        if (pushed != 10) begin bad++; $display("FAIL wrap_timeout got=%0d exp=10", pushed); end
        drain();
    endtask

    task automatic test_reset_mid();
        id_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_push(32'(100 + 4 * i));
            step();
        end
        rst = 1'b1;
        id_stall = 1'b0;
        drive_push(32'd200);
        step();
        rst = 1'b0;
        total += 2;
        if (count !== 3'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        if (id_valid !== 1'b0) begin bad++; $display("FAIL rstmid_id_valid got=%0b exp=0", id_valid); end
        drive_push(32'd300);
        step();
        if_valid = 1'b0;
        total++;
        if (id_PC !== 32'd300) begin bad++; $display("FAIL rstmid_first got=%0d exp=300", id_PC); end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_concurrent();
        test_flush();
        test_wrap();
        test_reset_mid();
        step();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
